// File: rtl/menu_pkg.sv
// Shared constants and types for the menu renderer: screen geometry, colours,
// selection FSM encoding, pixel-pipeline region tags and glyph ROM layout.
package menu_pkg;

  localparam int unsigned AddrW = 16;

  // Active display area
  localparam logic [9:0] ActiveW = 10'd640;
  localparam logic [9:0] ActiveH = 10'd480;

  // Title box, inclusive corners
  localparam logic [9:0] TitleX0 = 10'd170;
  localparam logic [9:0] TitleX1 = 10'd469;
  localparam logic [9:0] TitleY0 = 10'd150;
  localparam logic [9:0] TitleY1 = 10'd249;

  // Button i occupies y BtnY0+BtnPitch*i .. +BtnH
  localparam logic [9:0]  BtnX0    = 10'd200;
  localparam logic [9:0]  BtnX1    = 10'd439;
  localparam logic [9:0]  BtnY0    = 10'd270;
  localparam logic [9:0]  BtnH     = 10'd59;
  localparam int unsigned BtnPitch = 80;

  // Label sub-box inside each button; y offset is relative to the button top
  localparam logic [9:0] LblX0   = 10'd220;
  localparam logic [9:0] LblX1   = 10'd419;
  localparam logic [9:0] LblYOff = 10'd10;
  localparam logic [9:0] LblH    = 10'd39;

  // Box sizes in screen pixels, before scaling down to bitmap pixels
  localparam int unsigned TitleBoxW = 300;
  localparam int unsigned TitleBoxH = 100;
  localparam int unsigned LblBoxW   = 200;
  localparam int unsigned LblBoxH   = 40;

  // RGB444 colours
  localparam logic [11:0] ColBlack   = 12'h000;
  localparam logic [11:0] ColWhite   = 12'hfff;
  localparam logic [11:0] ColPressed = 12'h743;
  localparam logic [11:0] ColHover   = 12'h632;
  localparam logic [11:0] ColBtn     = 12'h521;

  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StConfirm,
    StLockout
  } menu_state_e;

  // Region tags travelling alongside the pixel pipeline; all-zero is background
  typedef struct packed {
    logic        active;
    logic        title;    // inside title box and title currently visible
    logic        label;
    logic        box;
    logic [11:0] box_col;
    logic [1:0]  idx;
  } px_tag_t;

  function automatic int unsigned title_w(input int unsigned shift);
    return TitleBoxW >> shift;
  endfunction

  function automatic int unsigned title_h(input int unsigned shift);
    return TitleBoxH >> shift;
  endfunction

  function automatic int unsigned label_w(input int unsigned shift);
    return LblBoxW >> shift;
  endfunction

  function automatic int unsigned label_h(input int unsigned shift);
    return LblBoxH >> shift;
  endfunction

  // ROM layout: title bitmap at 0, then each label bitmap back to back
  function automatic int unsigned label_base(input int unsigned idx, input int unsigned tshift,
                                             input int unsigned bshift);
    return title_w(tshift) * title_h(tshift) + idx * label_w(bshift) * label_h(bshift);
  endfunction

  function automatic int unsigned rom_depth(input int unsigned n_btn, input int unsigned tshift,
                                            input int unsigned bshift);
    return label_base(n_btn, tshift, bshift);
  endfunction

  // Bitmap art is procedural: diagonal stripes derived from the linear address
  function automatic logic glyph_bit(input logic [AddrW-1:0] addr);
    return addr[2] ^ addr[4];
  endfunction

endpackage

// File: rtl/menu_glyph_rom.sv
// Glyph ROM: title bitmap followed by the label bitmaps, 1-bit wide,
// registered read with one cycle of latency.
module menu_glyph_rom
  import menu_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [AddrW-1:0] addr_i,
  output logic             data_o
);

  logic data_q;

  // Registered read; addresses past the last bitmap read as blank
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= 1'b0;
    end else begin
      data_q <= (32'(addr_i) < Depth) ? glyph_bit(addr_i) : 1'b0;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/render_menu.sv
// Menu renderer: title plus stacked buttons drawn through a 3-stage pixel
// pipeline, with a frame-synchronous click FSM producing selection pulses.
module render_menu
  import menu_pkg::*;
#(
  parameter int unsigned N_BTN       = 2,
  parameter int unsigned TITLE_SHIFT = 2,
  parameter int unsigned BTN_SHIFT   = 1,
  parameter int unsigned LOCK_FRAMES = 8,
  parameter int unsigned BLINK_EN    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        frame_start,
  input  logic [9:0]  mouse_x,
  input  logic [9:0]  mouse_y,
  input  logic        mouse_btn,
  output logic [11:0] pixel,
  output logic        sel_valid,
  output logic [1:0]  sel_idx
);

  localparam int unsigned      RomDepth = rom_depth(N_BTN, TITLE_SHIFT, BTN_SHIFT);
  localparam logic [AddrW-1:0] TitleWA  = AddrW'(title_w(TITLE_SHIFT));
  localparam logic [AddrW-1:0] LblWA    = AddrW'(label_w(BTN_SHIFT));
  localparam int unsigned      LockW    = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
  localparam logic [LockW-1:0] LockMax  = LockW'(LOCK_FRAMES - 1);

  // Shadow cursor, frame counter and frame tick
  logic [9:0] mx_q, my_q;
  logic       mb_q;
  logic [5:0] frame_cnt_q;
  logic       tick_q;

  // Selection FSM
  menu_state_e      state_q;
  logic [1:0]       press_idx_q;
  logic [LockW-1:0] lock_cnt_q;
  logic             btn_prev_q;
  logic             sel_valid_q;
  logic [1:0]       sel_idx_q;

  // Hover decode
  logic       hover_valid;
  logic [1:0] hover_idx;
  logic [9:0] hy0;

  // Pixel pipeline
  px_tag_t          s1_tag_d, s1_tag_q, s2_tag_q;
  logic [9:0]       s1_row_d, s1_col_d, s1_row_q, s1_col_q;
  logic [9:0]       by0;
  logic             title_vis;
  logic [AddrW-1:0] rom_addr;
  logic             rom_bit;
  logic [11:0]      pixel_d, pixel_q;

  // Sample the cursor once per frame so highlighting cannot change mid-frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mx_q        <= '0;
      my_q        <= '0;
      mb_q        <= 1'b0;
      frame_cnt_q <= '0;
      tick_q      <= 1'b0;
    end else begin
      tick_q <= frame_start;
      if (frame_start) begin
        mx_q        <= mouse_x;
        my_q        <= mouse_y;
        mb_q        <= mouse_btn;
        frame_cnt_q <= frame_cnt_q + 6'd1;
      end
    end
  end

  // Which existing button box holds the shadow cursor
  always_comb begin
    hover_valid = 1'b0;
    hover_idx   = '0;
    hy0         = '0;
    for (int i = 0; i < N_BTN; i++) begin
      hy0 = BtnY0 + 10'(BtnPitch * i);
      if (mx_q >= BtnX0 && mx_q <= BtnX1 && my_q >= hy0 && my_q <= hy0 + BtnH) begin
        hover_valid = 1'b1;
        hover_idx   = 2'(i);
      end
    end
  end

  // Click FSM, stepped one cycle after each frame_start so it sees fresh shadows
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      press_idx_q <= '0;
      lock_cnt_q  <= '0;
      btn_prev_q  <= 1'b0;
      sel_valid_q <= 1'b0;
      sel_idx_q   <= '0;
    end else begin
      sel_valid_q <= 1'b0;
      if (tick_q) begin
        btn_prev_q <= mb_q;
      end
      unique case (state_q)
        StIdle: begin
          if (tick_q && mb_q && !btn_prev_q && hover_valid) begin
            state_q     <= StPressed;
            press_idx_q <= hover_idx;
          end
        end
        StPressed: begin
          if (tick_q && !mb_q) begin
            if (hover_valid && hover_idx == press_idx_q) begin
              state_q     <= StConfirm;
              sel_valid_q <= 1'b1;
              sel_idx_q   <= press_idx_q;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StConfirm: begin
          lock_cnt_q <= '0;
          state_q    <= (LOCK_FRAMES == 0) ? StIdle : StLockout;
        end
        StLockout: begin
          if (tick_q) begin
            if (lock_cnt_q == LockMax) begin
              state_q <= StIdle;
            end else begin
              lock_cnt_q <= lock_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign title_vis = (BLINK_EN == 0) || !frame_cnt_q[5];

  // S1: region decode and bitmap row/column by shifting box-relative coordinates
  always_comb begin
    s1_tag_d        = '0;
    s1_row_d        = '0;
    s1_col_d        = '0;
    by0             = '0;
    s1_tag_d.active = (h_cnt < ActiveW) && (v_cnt < ActiveH);
    if (h_cnt >= TitleX0 && h_cnt <= TitleX1 && v_cnt >= TitleY0 && v_cnt <= TitleY1) begin
      s1_tag_d.title = title_vis;
      s1_row_d       = (v_cnt - TitleY0) >> TITLE_SHIFT;
      s1_col_d       = (h_cnt - TitleX0) >> TITLE_SHIFT;
    end
    for (int i = 0; i < N_BTN; i++) begin
      by0 = BtnY0 + 10'(BtnPitch * i);
      if (h_cnt >= BtnX0 && h_cnt <= BtnX1 && v_cnt >= by0 && v_cnt <= by0 + BtnH) begin
        s1_tag_d.box = 1'b1;
        s1_tag_d.idx = 2'(i);
        if (h_cnt >= LblX0 && h_cnt <= LblX1 &&
            v_cnt >= by0 + LblYOff && v_cnt <= by0 + LblYOff + LblH) begin
          s1_tag_d.label = 1'b1;
          s1_row_d       = (v_cnt - by0 - LblYOff) >> BTN_SHIFT;
          s1_col_d       = (h_cnt - LblX0) >> BTN_SHIFT;
        end
      end
    end
    if (s1_tag_d.box) begin
      if (state_q == StPressed && s1_tag_d.idx == press_idx_q) begin
        s1_tag_d.box_col = ColPressed;
      end else if (hover_valid && hover_idx == s1_tag_d.idx) begin
        s1_tag_d.box_col = ColHover;
      end else begin
        s1_tag_d.box_col = ColBtn;
      end
    end
  end

  // S1 and S2 pipeline registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_tag_q <= '0;
      s1_row_q <= '0;
      s1_col_q <= '0;
      s2_tag_q <= '0;
    end else begin
      s1_tag_q <= s1_tag_d;
      s1_row_q <= s1_row_d;
      s1_col_q <= s1_col_d;
      s2_tag_q <= s1_tag_q;
    end
  end

  // S2: linear ROM address; the ROM's own read register is the S2 boundary
  always_comb begin
    rom_addr = '0;
    if (s1_tag_q.title) begin
      rom_addr = AddrW'(s1_row_q) * TitleWA + AddrW'(s1_col_q);
    end else if (s1_tag_q.label) begin
      rom_addr = AddrW'(label_base(32'(s1_tag_q.idx), TITLE_SHIFT, BTN_SHIFT)) +
                 AddrW'(s1_row_q) * LblWA + AddrW'(s1_col_q);
    end
  end

  menu_glyph_rom #(
    .Depth (RomDepth)
  ) u_glyph_rom (
    .clk_i  (clk),
    .rst_ni (rst),
    .addr_i (rom_addr),
    .data_o (rom_bit)
  );

  // S3: colour priority resolution
  always_comb begin
    pixel_d = ColBlack;
    if (!s2_tag_q.active) begin
      pixel_d = ColBlack;
    end else if ((s2_tag_q.title || s2_tag_q.label) && rom_bit) begin
      pixel_d = ColWhite;
    end else if (s2_tag_q.box) begin
      pixel_d = s2_tag_q.box_col;
    end
  end

  // S3 output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_q <= '0;
    end else begin
      pixel_q <= pixel_d;
    end
  end

  assign pixel     = pixel_q;
  assign sel_valid = sel_valid_q;
  assign sel_idx   = sel_idx_q;

endmodule
